// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronisation, frame debounce and press strobes.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe key_press every REPEAT_FRAMES frames while a key stays held.
module keypad_scanner #(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CNT  = 8,
    parameter int REPEAT_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_drv,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic       key_press
);

    localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [7:0]    SETTLE     = 8'(DEBOUNCE_CNT);
    localparam logic [0:0]    S_IDLE     = 1'b0;
    localparam logic [0:0]    S_HELD     = 1'b1;

    generate
        if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 255 || REPEAT_FRAMES < 1) begin : g_bad_params
            $error("keypad_scanner: parameter out of range");
        end
    endgenerate

    logic [3:0]    row_s1;
    logic [3:0]    row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    index;
    logic [15:0]   frame;
    logic [15:0]   frame_now;
    logic          last_dwell;
    logic          frame_end;
    logic [4:0]    bits_set;
    logic [7:0]    one_key;
    logic [7:0]    cand;
    logic [7:0]    prev_cand;
    logic [7:0]    stable;
    logic [7:0]    stable_next;
    logic          settled;
    logic [0:0]    state;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int            RW       = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_FRAMES - 1);
    logic [RW-1:0] rep_cnt;
`endif

    assign last_dwell = (dwell == DWELL_LAST);
    assign frame_end  = last_dwell && (index == 2'd3);
    assign col_drv    = 4'b0001 << index;
    assign key_valid  = (state == S_HELD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_s1 <= '0;
            row_s2 <= '0;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    // The current column's rows are merged in so the frame-end decision sees all 16 keys.
    always_comb begin
        frame_now = frame | (16'(row_s2) << {index, 2'b00});
        bits_set  = 5'd0;
        one_key   = 8'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (frame_now[c*4 + r]) begin
                    bits_set = bits_set + 5'd1;
                    one_key  = 8'((1 << (r + 4)) | (1 << c));
                end
            end
        end
        cand        = (bits_set == 5'd1) ? one_key : 8'd0;
        stable_next = (cand != prev_cand) ? 8'd1 :
                      (stable == 8'hFF)   ? stable : stable + 8'd1;
        settled     = (stable_next >= SETTLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell     <= '0;
            index     <= 2'd0;
            frame     <= '0;
            prev_cand <= 8'd0;
            stable    <= 8'd0;
        end else if (last_dwell) begin
            dwell <= '0;
            index <= index + 2'd1;
            frame <= frame_end ? 16'd0 : frame_now;
            if (frame_end) begin
                prev_cand <= cand;
                stable    <= stable_next;
            end
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    // A settled non-zero key different from the committed one commits directly, even from HELD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            key_press <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_press <= 1'b0;
            if (frame_end && settled) begin
                if (cand == 8'd0) begin
                    state <= S_IDLE;
                    row   <= '0;
                    col   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_cnt <= '0;
`endif
                end else if (state == S_IDLE || cand != {row, col}) begin
                    state     <= S_HELD;
                    row       <= cand[7:4];
                    col       <= cand[3:0];
                    key_press <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_cnt   <= '0;
`endif
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (rep_cnt == RPT_LAST) begin
                    key_press <= 1'b1;
                    rep_cnt   <= '0;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end that drives the 4x4 keypad columns one at a time, synchronises and samples the raw row lines, and debounces the result. It produces a stable one-hot `{row, col}` pair plus press strobes. It sits directly upstream of the keypad decoder, whose `row`/`col` inputs it feeds. The decoder turns that pair into a 5-bit key code; an all-zero pair decodes as idle.

## Interface
- `SCAN_DIV`, 1000: clock cycles each column is driven (dwell); must be >= 4.
- `DEBOUNCE_CNT`, 8: consecutive identical scan frames required to commit a change; range 1..255.
- `REPEAT_FRAMES`, 64: auto-repeat period in frames; used only with `KEYPAD_AUTOREPEAT_EN`.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `row_in`  in  4  raw keypad row lines, active-high when the key in the driven column is pressed; asynchronous.
- `col_drv`  out  4  one-hot column drive; bit0 is the left column.
- `row`  out  4  debounced one-hot row to the decoder; bit0 is the top row (1 2 3 A); 0 when idle.
- `col`  out  4  debounced one-hot column to the decoder; 0 when idle.
- `key_valid`  out  1  high while a debounced key is held (`row`/`col` non-zero).
- `key_press`  out  1  one-cycle strobe on each committed press (and on each repeat, when enabled).

## Operation
- **Column sequencing**
  - A dwell counter counts 0..SCAN_DIV-1.
  - At the wrap, the column index advances 0→1→2→3→0.
  - `col_drv` is `1 << index`.
- **Row synchronisation and sampling**
  - `row_in` passes through a 2-flop synchroniser.
  - On the last dwell cycle (count = SCAN_DIV-1), the synchronised rows are captured into a 16-bit frame register at column `index`.
- **Frame end** (last dwell cycle of column 3): a candidate is formed from the frame.
  - Exactly one bit set: candidate = that key's `{row, col}`.
  - Zero bits set: candidate = 0.
  - Two or more bits set (multi-key/ghosting): candidate = 0.
- **Debounce counter**
  - If the candidate equals the previous frame's candidate, `stable` increments, saturating at 255.
  - Otherwise `stable` = 1.
  - A candidate is "settled" when `stable` >= DEBOUNCE_CNT.
- **FSM states**
  - IDLE: outputs 0. A settled non-zero candidate causes a commit to HELD: load `row`/`col`, pulse `key_press`.
  - HELD: outputs hold the committed key.
    - A settled 0 returns to IDLE and clears the outputs.
    - A settled different non-zero key commits the new key directly, pulses `key_press` and stays in HELD.
    - The same key stays in HELD.
- The frame register is cleared after every frame end.

## Timing
- Frame length = 4 x SCAN_DIV cycles.
- Synchroniser latency is 2 cycles; SCAN_DIV >= 4 guarantees the sample reflects the driven column.
- Outputs are registered and update on the cycle after the frame-end sample.
- `key_press` is high for exactly that one cycle.
- Press latency: commit at the end of the DEBOUNCE_CNT-th consecutive frame showing the key. Release latency is the same.
- A bounce within the window resets `stable` to 1 and restarts the window.
- **Reset** (asynchronous, any time, including mid-frame):
  - `col_drv` = 4'b0001, `row` = 0, `col` = 0, `key_valid` = 0, `key_press` = 0.
  - FSM = IDLE; dwell, index, frame, `stable`, previous candidate and repeat counter = 0.
  - Scanning restarts at column 0, dwell 0, on the first clock after release.

## Configuration
- Macro `KEYPAD_AUTOREPEAT_EN`.
- **Defined:** in HELD, a frame counter restarts at each commit. Every REPEAT_FRAMES frames with the same key still settled, `key_press` pulses again; `row`/`col` are unchanged. The counter clears on release.
- **Undefined:** no repeat logic; `REPEAT_FRAMES` is ignored and `key_press` fires only on commit.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_FRAMES=4 (frame = 16 cycles).
1. Reset low mid-frame with key 5 held → outputs immediately at reset values, `col_drv` = 0001. After release, `col_drv` steps 0001, 0010, 0100, 1000, one step every 4 cycles.
2. Hold key 5 (`row_in[1]` high while col 1 is driven) clean → after the 3rd frame end, `row` = 0010, `col` = 0010, `key_valid` = 1, one-cycle `key_press`. Release → `row`/`col` = 0 after 3 frames.
3. Key 5 bouncing: present, absent, present, present, present (frames) → commit only at the end of the 5th frame.
4. Keys 1 and 6 held simultaneously → candidate 0; no `key_press`; outputs stay 0. If already HELD on key 1, it returns to IDLE after 3 frames.
5. Key 1 held, then switch directly to `#` (row 3, col 2) → `row`/`col` go 0001/0001 → 1000/0100 without passing through idle, with a second `key_press`.
6. With `KEYPAD_AUTOREPEAT_EN`, hold key D for 20 frames → `key_press` at commit and then every 4 frames (5 pulses total). Without the macro → 1 pulse.
